// File: rtl/capture_unit.sv
// Serial-to-word capture engine: samples dIn at a divided bit rate, packs bits MSB-first
// into 32-bit words and hands each word to a downstream write FIFO until the requested count is pushed.
module capture_unit #(
  parameter int CLK_DIV = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             enable,
  input  logic [CNT_W-1:0] captureNum,
  input  logic             dIn,
  input  logic             dValid,
  input  logic             fifoFull,
  output logic [31:0]      captureData,
  output logic             pushWrite,
  output logic [CNT_W-1:0] wordCount,
  output logic             complete,
  output logic             overflow
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;

  state_t           state, nextState;
  logic [DIV_W-1:0] divider;
  logic [4:0]       bitCnt;
  logic [31:0]      shiftReg;
  logic [31:0]      holdReg;
  logic             pending;
  logic [CNT_W-1:0] reqNum;
  logic [CNT_W-1:0] needed;
  logic             running;
  logic             sample;
  logic             wordDone;

  // Words still to be assembled: those neither pushed nor waiting in holdReg.
  assign needed   = reqNum - wordCount - CNT_W'(pending);
  assign running  = (state == SHIFT) || (state == DRAIN);
  assign sample   = (state == SHIFT) && enable && (needed != '0)
                    && (divider == DIV_MAX) && dValid;
  assign wordDone = sample && (bitCnt == 5'd31);

  // Gated by enable and resetN so neither an abort nor a reset cycle can emit a strobe.
  assign pushWrite   = pending && !fifoFull && enable && resetN;
  assign captureData = holdReg;
  assign complete    = (state == DONE);

  always_ff @(posedge clk) begin
    if (!resetN) state <= IDLE;
    else         state <= nextState;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (enable) nextState = (captureNum == '0) ? DONE : SHIFT;
      SHIFT: if (!enable) nextState = IDLE;
             else if (needed == '0) nextState = DRAIN;
      DRAIN: if (!enable) nextState = IDLE;
             else if (!pending && (wordCount == reqNum)) nextState = DONE;
      DONE:  if (!enable) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // NOTE: reset here is synchronous (sampled on the clock edge) and all state uses <=.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      divider   <= '0;
      bitCnt    <= '0;
      shiftReg  <= '0;
      holdReg   <= '0;
      pending   <= 1'b0;
      reqNum    <= '0;
      wordCount <= '0;
      overflow  <= 1'b0;
    end else if (state == IDLE && enable) begin
      reqNum    <= captureNum;
      wordCount <= '0;
      overflow  <= 1'b0;
      bitCnt    <= '0;
      divider   <= '0;
      pending   <= 1'b0;
    end else if (running && !enable) begin
      pending <= 1'b0;
    end else begin
      if (state == SHIFT) divider <= (divider == DIV_MAX) ? '0 : divider + 1'b1;
      if (sample) begin
        shiftReg <= {shiftReg[30:0], dIn};
        bitCnt   <= bitCnt + 5'd1;
      end
      // A push in the same cycle frees holdReg, so a completing word can take its place.
      if (wordDone) begin
        if (!pending || pushWrite) begin
          holdReg <= {shiftReg[30:0], dIn};
          pending <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (pushWrite) begin
        pending <= 1'b0;
      end
      if (pushWrite) wordCount <= wordCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_capture_unit.sv
// Directed bench for capture_unit: stimulus enqueues expected words, a negedge monitor
// pops and compares on every pushWrite strobe.
module tb_capture_unit;

  localparam int CLK_DIV = 2;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             resetN;
  logic             enable;
  logic [CNT_W-1:0] captureNum;
  logic             dIn;
  logic             dValid;
  logic             fifoFull;
  logic [31:0]      captureData;
  logic             pushWrite;
  logic [CNT_W-1:0] wordCount;
  logic             complete;
  logic             overflow;

  int          checks = 0;
  int          errors = 0;
  int          tickIdx = 0;
  logic [31:0] sb[$];

  capture_unit #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetN(resetN), .enable(enable), .captureNum(captureNum),
    .dIn(dIn), .dValid(dValid), .fifoFull(fifoFull),
    .captureData(captureData), .pushWrite(pushWrite), .wordCount(wordCount),
    .complete(complete), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (pushWrite) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_push: got 0x%08h, expected no push", captureData);
      end else begin
        check("push_data", captureData, sb.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Holds one bit for a full divider period, aligned so the tick cycle sees it.
  task automatic sendBit(input logic b, input bit gap);
    if (gap && (tickIdx % 3 == 2)) begin
      dValid = 1'b0;
      dIn    = ~b;
      tickIdx++;
      repeat (CLK_DIV) @(negedge clk);
    end
    dValid = 1'b1;
    dIn    = b;
    tickIdx++;
    repeat (CLK_DIV) @(negedge clk);
  endtask

  task automatic sendWord(input logic [31:0] w, input bit gap);
    for (int i = 31; i >= 0; i--) sendBit(w[i], gap);
    dValid = 1'b0;
  endtask

  task automatic startCapture(input logic [CNT_W-1:0] num);
    @(negedge clk);
    captureNum = num;
    enable     = 1'b1;
    tickIdx    = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic waitComplete(input int budget);
    int n = 0;
    while (!complete && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("complete_set", {31'd0, complete}, 32'd1);
  endtask

  task automatic stopCapture();
    enable = 1'b0;
    @(negedge clk);
    check("complete_clear", {31'd0, complete}, 32'd0);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    resetN = 1'b0; enable = 1'b0; captureNum = '0;
    dIn = 1'b0; dValid = 1'b0; fifoFull = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_data", captureData, 32'h0);
    check("rst_flags", {pushWrite, complete, overflow}, 32'h0);
    check("rst_count", wordCount, 32'h0);
    resetN = 1'b1;

    // Basic two-word capture.
    sb.push_back(32'h6F3B2A1C);
    sb.push_back(32'h12345678);
    startCapture(16'd2);
    sendWord(32'h6F3B2A1C, 1'b0);
    sendWord(32'h12345678, 1'b0);
    waitComplete(20);
    check("basic_count", wordCount, 32'd2);
    check("basic_ovf", {31'd0, overflow}, 32'd0);
    stopCapture();

    // Same words with every third tick invalid.
    sb.push_back(32'h6F3B2A1C);
    sb.push_back(32'h12345678);
    startCapture(16'd2);
    sendWord(32'h6F3B2A1C, 1'b1);
    sendWord(32'h12345678, 1'b1);
    waitComplete(20);
    check("gap_count", wordCount, 32'd2);
    check("gap_ovf", {31'd0, overflow}, 32'd0);
    stopCapture();

    // Backpressure: FIFO full until 20+ cycles after the first word completes.
    sb.push_back(32'h6F3B2A1C);
    sb.push_back(32'h12345678);
    startCapture(16'd2);
    fifoFull = 1'b1;
    fork
      begin
        sendWord(32'h6F3B2A1C, 1'b0);
        sendWord(32'h12345678, 1'b0);
      end
      begin
        repeat (75) @(negedge clk);
        check("bp_held_data", captureData, 32'h6F3B2A1C);
        check("bp_no_push", {31'd0, pushWrite}, 32'd0);
        repeat (11) @(negedge clk);
        fifoFull = 1'b0;
        repeat (2) @(negedge clk);
        check("bp_count_one", wordCount, 32'd1);
      end
    join
    waitComplete(20);
    check("bp_count", wordCount, 32'd2);
    stopCapture();

    // Overflow: second word arrives while the first is still blocked.
    sb.push_back(32'h33333333);
    sb.push_back(32'hBB1BB1BB);
    sb.push_back(32'h1BBBBBB1);
    startCapture(16'd3);
    fifoFull = 1'b1;
    fork
      begin
        sendWord(32'h33333333, 1'b0);
        sendWord(32'h456789AB, 1'b0);
        sendWord(32'hBB1BB1BB, 1'b0);
        sendWord(32'h1BBBBBB1, 1'b0);
      end
      begin
        repeat (144) @(negedge clk);
        fifoFull = 1'b0;
      end
    join
    waitComplete(20);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_count", wordCount, 32'd3);
    stopCapture();

    // Zero request completes without any push.
    @(negedge clk);
    captureNum = '0;
    enable     = 1'b1;
    waitComplete(3);
    check("zero_count", wordCount, 32'd0);
    stopCapture();

    // Abort mid-word, then restart with a single word.
    startCapture(16'd2);
    for (int i = 0; i < 17; i++) sendBit(1'b1, 1'b0);
    dValid = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_complete", {31'd0, complete}, 32'd0);
    check("abort_count", wordCount, 32'd0);
    sb.push_back(32'h0F0F0F0F);
    startCapture(16'd1);
    sendWord(32'h0F0F0F0F, 1'b0);
    waitComplete(20);
    check("restart_count", wordCount, 32'd1);
    stopCapture();

    // Reset mid-word after one push: all outputs return to zero.
    sb.push_back(32'h0F0F0F0F);
    startCapture(16'd2);
    sendWord(32'h0F0F0F0F, 1'b0);
    for (int i = 0; i < 10; i++) sendBit(1'b0, 1'b0);
    resetN = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    check("mrst_data", captureData, 32'h0);
    check("mrst_count", wordCount, 32'h0);
    check("mrst_flags", {pushWrite, complete, overflow}, 32'h0);
    resetN = 1'b1;
    dValid = 1'b0;
    repeat (2) @(negedge clk);
    check("sb_final", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
